rom_loader_ctrl: RTL and testbench
==================================

# rom_loader_ctrl

Sequences the SD card controller to copy a contiguous run of 512-byte sectors into the cartridge ROM write port, so a game selected from the menu replaces the boot image. It sits between the menu control logic and `sd_controller`: it drives `rd`/`address`, consumes the `dout`/`byte_available` stream, and produces single-cycle byte writes into cartridge memory. It reports busy, completion, truncation and error status back to the menu/Atari-visible register block.

## Interface
- `MEM_DEPTH`, 49152: bytes of cartridge ROM; write addresses run 0..MEM_DEPTH-1.
- `SECTOR_BYTES`, 512: bytes expected per sector read.
- `IDLE_STATUS`, 6: `sd_status` value meaning the card is initialised and idle.
- `TIMEOUT_CYCLES`, 2700000: max cycles waiting in any wait state (~100 ms at 27 MHz).

- `clk` in 1: system clock, 27 MHz.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle load request.
- `start_sector` in 32: first SDHC sector number.
- `sector_count` in 8: number of sectors to load.
- `sd_ready` in 1: controller ready.
- `sd_status` in 5: controller state.
- `sd_byte_available` in 1: controller byte strobe (level, edge-detected here).
- `sd_dout` in 8: controller read data.
- `sd_rd` out 1: read request.
- `sd_address` out 32: sector number presented to controller.
- `mem_we` out 1: ROM write strobe.
- `mem_addr` out 16: ROM write address.
- `mem_wdata` out 8: ROM write data.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky; timeout or short sector.
- `truncated` out 1: sticky; bytes arrived past MEM_DEPTH.
- `bytes_loaded` out 17: bytes written to memory in current/last load.

## Operation
- States: IDLE, WAIT_CARD, ISSUE, STREAM, NEXT, FINISH, FAIL.
- IDLE: `start`=1 latches `start_sector`, `sector_count`; clears `error`, `truncated`, `bytes_loaded`, `mem_addr`; goes to WAIT_CARD. `sector_count`=0 goes to FINISH instead (no reads). `start` outside IDLE is ignored.
- WAIT_CARD: wait for `sd_ready`=1 and `sd_status`=IDLE_STATUS -> ISSUE.
- ISSUE: `sd_address` = current sector, `sd_rd`=1 held until `sd_ready`=0 is observed; then `sd_rd`=0, byte counter cleared, -> STREAM.
- STREAM: rising edge of `sd_byte_available` (level vs previous-cycle copy) is one byte. Byte written if `mem_addr` < MEM_DEPTH, else dropped and `truncated` set. `sd_ready` returning to 1 ends the sector: byte count = SECTOR_BYTES -> NEXT; otherwise -> FAIL.
- NEXT: decrement remaining count, increment sector; remaining 0 -> FINISH, else -> WAIT_CARD.
- FINISH: pulse `done`, -> IDLE. FAIL: set `error`, -> IDLE (no `done`).
- Timeout counter clears on every state entry and every accepted byte; reaching TIMEOUT_CYCLES in WAIT_CARD, ISSUE or STREAM -> FAIL.
- `mem_addr` saturates at MEM_DEPTH (never wraps); `bytes_loaded` counts written bytes only.

## Timing
- Reset: all outputs 0, state IDLE, `sd_address` 0.
- `busy`=1 from the cycle after `start` accepted until the cycle FINISH/FAIL returns to IDLE.
- Byte edge detected on cycle N -> `mem_we`=1, `mem_wdata`=byte sampled at N, `mem_addr`=current address on cycle N+1; address increments after the write. `mem_we` never high two consecutive cycles.
- Byte edge and `sd_ready` rise in the same cycle: byte is counted before the end-of-sector check.
- `done` pulse width exactly 1 cycle; `error`/`truncated` hold until next accepted `start` or reset.
- `reset` mid-load: `sd_rd` and `mem_we` low next cycle, no further writes.

## Configuration
- `LOADER_HEADER_SKIP_EN`: defined -> first 128 bytes of the first sector of each load (A78 header) are counted toward SECTOR_BYTES but not written; first written byte is byte 128 at `mem_addr` 0. Undefined -> every byte written from address 0.

## Test plan
- `start_sector`=2055, `sector_count`=2, model streams 1024 bytes of value index[7:0] -> 1024 `mem_we` pulses, addr 0..1023, `done` 1 pulse, `bytes_loaded`=1024, `error`=0.
- `sector_count`=0 -> `sd_rd` never asserted, `done` pulses 2 cycles after `start`.
- Model ends sector after 500 bytes -> `error`=1, no `done`, `busy` drops, sector 2 never requested.
- `sd_ready` held high after `sd_rd` -> FAIL after TIMEOUT_CYCLES, `sd_rd` low, `error`=1.
- MEM_DEPTH=1024, `sector_count`=3 -> writes stop at addr 1023, `truncated`=1, `done` pulses, `bytes_loaded`=1024.
- `reset` asserted at byte 300 of sector 1, then new `start` -> clean restart from addr 0; with `LOADER_HEADER_SKIP_EN` first write carries byte 128.

Source files
------------

// File: rtl/rom_loader_ctrl.sv
// Copies a run of SD-card sectors into the cartridge ROM write port.
// Optional build macro LOADER_HEADER_SKIP_EN drops the 128-byte A78 header of the first sector.
module rom_loader_ctrl #(
  parameter int unsigned MEM_DEPTH      = 49152,
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned IDLE_STATUS    = 6,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_sector,
  input  logic [7:0]  sector_count,
  input  logic        sd_ready,
  input  logic [4:0]  sd_status,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        truncated,
  output logic [16:0] bytes_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CARD, S_ISSUE, S_STREAM, S_NEXT, S_FINISH, S_FAIL
  } state_e;

  localparam logic [16:0] MEM_LIMIT    = 17'(MEM_DEPTH);
  localparam logic [15:0] SECTOR_LIMIT = 16'(SECTOR_BYTES);
  localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  IDLE_CODE    = 5'(IDLE_STATUS);
  localparam logic [15:0] HEADER_BYTES = 16'd128;
`ifdef LOADER_HEADER_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] sector_q, sector_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic        avail_q;
  logic        first_sector_q, first_sector_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [16:0] loaded_q, loaded_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        trunc_q, trunc_d;

  logic byte_edge, stream_byte, skip_byte, write_ok, timed_out;

  // The strobe is a level; one byte per low-to-high transition.
  assign byte_edge   = sd_byte_available & ~avail_q;
  assign stream_byte = (state_q == S_STREAM) && byte_edge;
  assign skip_byte   = SKIP_EN && first_sector_q && (byte_cnt_q < HEADER_BYTES);
  assign write_ok    = {1'b0, addr_q} < MEM_LIMIT;
  assign timed_out   = tmo_q >= TMO_LAST;

  // NOTE: every next-state variable gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    sector_d       = sector_q;
    remaining_d    = remaining_q;
    byte_cnt_d     = byte_cnt_q;
    first_sector_d = first_sector_q;
    we_d           = 1'b0;
    wdata_d        = wdata_q;
    addr_d         = addr_q;
    loaded_d       = loaded_q;
    done_d         = 1'b0;
    error_d        = error_q;
    trunc_d        = trunc_q;

    // A write issued last cycle retires now; address moves only after it is presented.
    if (we_q) begin
      addr_d   = addr_q + 16'd1;
      loaded_d = loaded_q + 17'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sector_d       = start_sector;
          remaining_d    = sector_count;
          first_sector_d = 1'b1;
          error_d        = 1'b0;
          trunc_d        = 1'b0;
          loaded_d       = '0;
          addr_d         = '0;
          state_d        = (sector_count == 8'd0) ? S_FINISH : S_WAIT_CARD;
        end
      end
      S_WAIT_CARD: begin
        if (sd_ready && (sd_status == IDLE_CODE)) state_d = S_ISSUE;
        else if (timed_out)                       state_d = S_FAIL;
      end
      S_ISSUE: begin
        if (!sd_ready) begin
          byte_cnt_d = '0;
          state_d    = S_STREAM;
        end else if (timed_out) begin
          state_d = S_FAIL;
        end
      end
      S_STREAM: begin
        if (stream_byte) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (!skip_byte) begin
            if (write_ok) begin
              we_d    = 1'b1;
              wdata_d = sd_dout;
            end else begin
              trunc_d = 1'b1;
            end
          end
        end
        // A byte arriving with the ready rise is already in byte_cnt_d.
        if (sd_ready)                       state_d = (byte_cnt_d == SECTOR_LIMIT) ? S_NEXT : S_FAIL;
        else if (timed_out && !stream_byte) state_d = S_FAIL;
      end
      S_NEXT: begin
        remaining_d    = remaining_q - 8'd1;
        sector_d       = sector_q + 32'd1;
        first_sector_d = 1'b0;
        state_d        = (remaining_q == 8'd1) ? S_FINISH : S_WAIT_CARD;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmo_d = tmo_q;
    if ((state_d != state_q) || stream_byte) tmo_d = '0;
    else if (!timed_out)                     tmo_d = tmo_q + 32'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sector_q       <= '0;
      remaining_q    <= '0;
      byte_cnt_q     <= '0;
      tmo_q          <= '0;
      avail_q        <= 1'b0;
      first_sector_q <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      addr_q         <= '0;
      loaded_q       <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      trunc_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sector_q       <= sector_d;
      remaining_q    <= remaining_d;
      byte_cnt_q     <= byte_cnt_d;
      tmo_q          <= tmo_d;
      avail_q        <= sd_byte_available;
      first_sector_q <= first_sector_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      addr_q         <= addr_d;
      loaded_q       <= loaded_d;
      done_q         <= done_d;
      error_q        <= error_d;
      trunc_q        <= trunc_d;
    end
  end

  assign sd_rd        = (state_q == S_ISSUE);
  assign sd_address   = sector_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign truncated    = trunc_q;
  assign bytes_loaded = loaded_q;

endmodule

// File: tb/tb_rom_loader_ctrl.sv
// Directed bench for rom_loader_ctrl: SD controller model plus write-port monitor.
module tb_rom_loader_ctrl;

  localparam int TMO = 300;
`ifdef LOADER_HEADER_SKIP_EN
  localparam int SKIP = 128;
`else
  localparam int SKIP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, sd_ready, sd_byte_available;
  logic [31:0] start_sector;
  logic [7:0]  sector_count, sd_dout;
  logic [4:0]  sd_status;
  logic        sd_rd, mem_we, busy, done, error, truncated;
  logic [31:0] sd_address;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [16:0] bytes_loaded;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  logic we_prev = 1'b0;

  rom_loader_ctrl #(.MEM_DEPTH(1024), .SECTOR_BYTES(512), .IDLE_STATUS(6), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .sd_ready(sd_ready), .sd_status(sd_status),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout), .sd_rd(sd_rd),
    .sd_address(sd_address), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .truncated(truncated), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Write n-th of a load must land at address n carrying load byte n+SKIP.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [31:0] d;
      d = wr_cnt + SKIP;
      check("wr_addr", {16'b0, mem_addr}, wr_cnt);
      check("wr_data", {24'b0, mem_wdata}, {24'b0, d[7:0]});
      check("we_back_to_back", {31'b0, we_prev}, 0);
      wr_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (sd_rd === 1'b1) rd_cnt++;
    we_prev = mem_we;
  end

  task automatic wait_rd(input logic val, input string tag);
    for (int k = 0; k < 64 && sd_rd !== val; k++) tick;
    check(tag, {31'b0, sd_rd}, {31'b0, val});
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 64 && busy !== 1'b0; k++) tick;
    check(tag, {31'b0, busy}, 0);
    tick;
  endtask

  task automatic do_start(input logic [31:0] sec, input logic [7:0] cnt);
    wr_cnt = 0;
    done_cnt = 0;
    rd_cnt = 0;
    start_sector = sec;
    sector_count = cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic stream_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = base + i;
      sd_dout = v[7:0];
      sd_byte_available = 1'b1;
      tick;
      tick;
      sd_byte_available = 1'b0;
      tick;
      tick;
    end
  endtask

  task automatic serve_sector(input int exp_sector, input int n, input int base);
    wait_rd(1'b1, "rd_rise");
    check("sd_address", sd_address, exp_sector);
    sd_ready = 1'b0;
    wait_rd(1'b0, "rd_fall");
    stream_bytes(n, base);
    sd_ready = 1'b1;
    tick;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; start_sector = '0; sector_count = '0;
    sd_ready = 1'b1; sd_status = 5'd6; sd_byte_available = 1'b0; sd_dout = '0;
    tick; tick;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_sd_rd", {31'b0, sd_rd}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_error", {31'b0, error}, 0);
    check("rst_truncated", {31'b0, truncated}, 0);
    check("rst_sd_address", sd_address, 0);
    check("rst_bytes_loaded", {15'b0, bytes_loaded}, 0);
    reset = 1'b0;
    tick;

    // Two full sectors from 2055.
    do_start(32'd2055, 8'd2);
    check("t1_busy", {31'b0, busy}, 1);
    serve_sector(2055, 512, 0);
    serve_sector(2056, 512, 512);
    wait_idle("t1_idle");
    check("t1_done_cnt", done_cnt, 1);
    check("t1_writes", wr_cnt, 1024 - SKIP);
    check("t1_bytes_loaded", {15'b0, bytes_loaded}, 1024 - SKIP);
    check("t1_error", {31'b0, error}, 0);
    check("t1_truncated", {31'b0, truncated}, 0);

    // Zero sectors: straight to FINISH.
    do_start(32'd9, 8'd0);
    check("t2_busy", {31'b0, busy}, 1);
    check("t2_done_early", {31'b0, done}, 0);
    tick;
    check("t2_done", {31'b0, done}, 1);
    check("t2_busy_low", {31'b0, busy}, 0);
    tick;
    check("t2_done_width", {31'b0, done}, 0);
    check("t2_no_rd", rd_cnt, 0);

    // Short sector: 500 bytes then ready.
    do_start(32'd100, 8'd2);
    serve_sector(100, 500, 0);
    wait_idle("t3_idle");
    check("t3_error", {31'b0, error}, 1);
    check("t3_bytes_loaded", {15'b0, bytes_loaded}, 500 - SKIP);
    rd_cnt = 0;
    repeat (20) tick;
    check("t3_no_second_rd", rd_cnt, 0);
    check("t3_no_done", done_cnt, 0);

    // Controller never drops ready after rd.
    do_start(32'd7, 8'd1);
    check("t4_error_cleared", {31'b0, error}, 0);
    wait_rd(1'b1, "t4_rd_rise");
    n = 0;
    while (busy === 1'b1 && n < TMO + 50) begin
      tick;
      n++;
    end
    check("t4_timeout_cycles", n, TMO + 1);
    check("t4_sd_rd", {31'b0, sd_rd}, 0);
    check("t4_error", {31'b0, error}, 1);
    check("t4_no_done", done_cnt, 0);

    // Three sectors into a 1024-byte ROM.
    do_start(32'd300, 8'd3);
    serve_sector(300, 512, 0);
    serve_sector(301, 512, 512);
    serve_sector(302, 512, 1024);
    wait_idle("t5_idle");
    check("t5_truncated", {31'b0, truncated}, 1);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_writes", wr_cnt, 1024);
    check("t5_bytes_loaded", {15'b0, bytes_loaded}, 1024);
    check("t5_mem_addr_sat", {16'b0, mem_addr}, 1024);
    check("t5_error", {31'b0, error}, 0);

    // Reset in the middle of sector 1, then a clean reload.
    do_start(32'd50, 8'd2);
    wait_rd(1'b1, "t6_rd_rise");
    sd_ready = 1'b0;
    wait_rd(1'b0, "t6_rd_fall");
    stream_bytes(300, 0);
    sd_dout = 8'hAA;
    sd_byte_available = 1'b1;
    reset = 1'b1;
    tick;
    check("t6_rst_sd_rd", {31'b0, sd_rd}, 0);
    check("t6_rst_mem_we", {31'b0, mem_we}, 0);
    check("t6_rst_busy", {31'b0, busy}, 0);
    wr_cnt = 0;
    reset = 1'b0;
    sd_byte_available = 1'b0;
    sd_ready = 1'b1;
    repeat (10) tick;
    check("t6_no_writes_after_rst", wr_cnt, 0);
    do_start(32'd60, 8'd1);
    serve_sector(60, 512, 0);
    wait_idle("t6_idle");
    check("t6_done_cnt", done_cnt, 1);
    check("t6_writes", wr_cnt, 512 - SKIP);
    check("t6_bytes_loaded", {15'b0, bytes_loaded}, 512 - SKIP);
    check("t6_error", {31'b0, error}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
